// File: rtl/rvc_asap_cr_ctrl.sv
// Control-register block: 7-segment, LED and cursor registers, synchronized switches,
// and debounced push-buttons with sticky rising-edge event flags.
module rvc_asap_cr_ctrl #(
    parameter int unsigned NUM_SEG7     = 6,
    parameter int unsigned LED_W        = 10,
    parameter int unsigned NUM_BTN      = 2,
    parameter int unsigned SW_W         = 10,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter logic [31:0] CR_BASE      = 32'h2000
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  CrWrEn,
    input  logic                  CrRdEn,
    input  logic [31:0]           CrAddr,
    input  logic [31:0]           CrWrData,
    output logic [31:0]           CrRdData,
    input  logic [NUM_BTN-1:0]    Button,
    input  logic [SW_W-1:0]       Switch,
    output logic [7*NUM_SEG7-1:0] Seg7,
    output logic [LED_W-1:0]      Led,
    output logic [31:0]           CursorH,
    output logic [31:0]           CursorV
);

    localparam int unsigned    CNT_W   = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    localparam logic [5:0] IDX_LED = 6'd16;
    localparam logic [5:0] IDX_LVL = 6'd17;
    localparam logic [5:0] IDX_EVT = 6'd18;
    localparam logic [5:0] IDX_SW  = 6'd19;
    localparam logic [5:0] IDX_CH  = 6'd20;
    localparam logic [5:0] IDX_CV  = 6'd21;

    logic [6:0]         seg_q [NUM_SEG7];
    logic [LED_W-1:0]   led_q;
    logic [31:0]        cur_h_q, cur_v_q, rd_data_q;
    logic [NUM_BTN-1:0] btn_s1_q, btn_s2_q, lvl_q, lvl_d, evt_q, evt_d, evt_clr;
    logic [SW_W-1:0]    sw_s1_q, sw_s2_q;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];

    logic       hit, wr_hit;
    logic [5:0] widx;
    logic [31:0] rd_val;
    logic [1:0] unused_addr_lsb;

    assign hit             = (CrAddr[31:8] == CR_BASE[31:8]);
    assign wr_hit          = CrWrEn && hit;
    assign widx            = CrAddr[7:2];
    assign unused_addr_lsb = CrAddr[1:0];

    // Read mux works on current state, so a same-cycle write returns the old value.
    always_comb begin
        rd_val = '0;
        if (hit) begin
            for (int i = 0; i < NUM_SEG7; i++) begin
                if (widx == 6'(i)) rd_val = 32'(seg_q[i]);
            end
            case (widx)
                IDX_LED: rd_val = 32'(led_q);
                IDX_LVL: rd_val = 32'(lvl_q);
                IDX_EVT: rd_val = 32'(evt_q);
                IDX_SW:  rd_val = 32'(sw_s2_q);
                IDX_CH:  rd_val = cur_h_q;
                IDX_CV:  rd_val = cur_v_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        lvl_d = lvl_q;
        for (int b = 0; b < NUM_BTN; b++) begin
            cnt_d[b] = '0;
            if (btn_s2_q[b] != lvl_q[b]) begin
                if (cnt_q[b] >= CNT_MAX) lvl_d[b] = btn_s2_q[b];
                else                     cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
    end

    // A rising debounced edge overrides a same-cycle clear.
    always_comb begin
        evt_clr = (wr_hit && widx == IDX_EVT) ? CrWrData[NUM_BTN-1:0] : '0;
        evt_d   = (evt_q & ~evt_clr) | (lvl_d & ~lvl_q);
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            for (int i = 0; i < NUM_SEG7; i++) seg_q[i] <= '0;
            for (int b = 0; b < NUM_BTN; b++) cnt_q[b] <= '0;
            led_q     <= '0;
            cur_h_q   <= '0;
            cur_v_q   <= '0;
            rd_data_q <= '0;
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            lvl_q     <= '0;
            evt_q     <= '0;
        end else begin
            btn_s1_q <= Button;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= Switch;
            sw_s2_q  <= sw_s1_q;
            lvl_q    <= lvl_d;
            evt_q    <= evt_d;
            for (int b = 0; b < NUM_BTN; b++) cnt_q[b] <= cnt_d[b];
            if (CrRdEn) rd_data_q <= rd_val;
            if (wr_hit) begin
                for (int i = 0; i < NUM_SEG7; i++) begin
                    if (widx == 6'(i)) seg_q[i] <= CrWrData[6:0];
                end
                case (widx)
                    IDX_LED: led_q   <= CrWrData[LED_W-1:0];
                    IDX_CH:  cur_h_q <= CrWrData;
                    IDX_CV:  cur_v_q <= CrWrData;
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_SEG7; g++) begin : g_seg
        assign Seg7[7*g +: 7] = seg_q[g];
    end

    assign Led      = led_q;
    assign CursorH  = cur_h_q;
    assign CursorV  = cur_v_q;
    assign CrRdData = rd_data_q;

endmodule

// File: tb/tb_rvc_asap_cr_ctrl.sv
// Bench for rvc_asap_cr_ctrl: register-map model plus stability-based debounce model,
// compared every cycle, with directed literal expectations.
module tb_rvc_asap_cr_ctrl;

    localparam int          NS   = 6;
    localparam int          LW   = 10;
    localparam int          NB   = 2;
    localparam int          SWW  = 10;
    localparam int          DEB  = 16;
    localparam logic [31:0] BASE = 32'h2000;

    logic            Clock, Rst, CrWrEn, CrRdEn;
    logic [31:0]     CrAddr, CrWrData, CrRdData, CursorH, CursorV;
    logic [NB-1:0]   Button;
    logic [SWW-1:0]  Switch;
    logic [7*NS-1:0] Seg7;
    logic [LW-1:0]   Led;

    rvc_asap_cr_ctrl #(
        .NUM_SEG7    (NS),
        .LED_W       (LW),
        .NUM_BTN     (NB),
        .SW_W        (SWW),
        .DEBOUNCE_CYC(DEB),
        .CR_BASE     (BASE)
    ) dut (
        .Clock   (Clock),
        .Rst     (Rst),
        .CrWrEn  (CrWrEn),
        .CrRdEn  (CrRdEn),
        .CrAddr  (CrAddr),
        .CrWrData(CrWrData),
        .CrRdData(CrRdData),
        .Button  (Button),
        .Switch  (Switch),
        .Seg7    (Seg7),
        .Led     (Led),
        .CursorH (CursorH),
        .CursorV (CursorV)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_pass = 0;
    int n_total = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state
    logic [6:0]     m_seg [NS];
    logic [LW-1:0]  m_led;
    logic [31:0]    m_ch, m_cv, m_rd;
    logic [NB-1:0]  m_lvl, m_evt, m_clr, m_s, m_prev;
    logic [NB-1:0]  m_bd [2];
    logic [SWW-1:0] m_swd [2];
    int             m_stable [NB];
    int             m_off;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int off;
        off = int'(a[7:2]) * 4;
        if (a[31:8] != BASE[31:8]) return 32'h0;
        if (off < 4 * NS) return 32'(m_seg[off / 4]);
        case (off)
            'h40: return 32'(m_led);
            'h44: return 32'(m_lvl);
            'h48: return 32'(m_evt);
            'h4C: return 32'(m_swd[1]);
            'h50: return m_ch;
            'h54: return m_cv;
            default: return 32'h0;
        endcase
    endfunction

    // Debounced level follows the synchronized input once it has been stable for DEB samples.
    always @(posedge Clock) begin
        if (Rst) begin
            for (int i = 0; i < NS; i++) m_seg[i] = '0;
            for (int b = 0; b < NB; b++) m_stable[b] = 0;
            m_led = '0; m_ch = '0; m_cv = '0; m_rd = '0;
            m_lvl = '0; m_evt = '0; m_prev = '0;
            m_bd[0] = '0; m_bd[1] = '0; m_swd[0] = '0; m_swd[1] = '0;
        end else begin
            if (CrRdEn) m_rd = m_read(CrAddr);
            m_clr = '0;
            if (CrWrEn && CrAddr[31:8] == BASE[31:8]) begin
                m_off = int'(CrAddr[7:2]) * 4;
                if (m_off < 4 * NS) m_seg[m_off / 4] = CrWrData[6:0];
                else begin
                    case (m_off)
                        'h40: m_led = CrWrData[LW-1:0];
                        'h48: m_clr = CrWrData[NB-1:0];
                        'h50: m_ch  = CrWrData;
                        'h54: m_cv  = CrWrData;
                        default: ;
                    endcase
                end
            end
            m_evt = m_evt & ~m_clr;
            m_s = m_bd[1];
            for (int b = 0; b < NB; b++) begin
                if (m_s[b] == m_prev[b]) m_stable[b]++;
                else m_stable[b] = 1;
                m_prev[b] = m_s[b];
                if (m_stable[b] >= DEB && m_s[b] != m_lvl[b]) begin
                    m_lvl[b] = m_s[b];
                    if (m_s[b]) m_evt[b] = 1'b1;
                end
            end
            m_bd[1] = m_bd[0]; m_bd[0] = Button;
            m_swd[1] = m_swd[0]; m_swd[0] = Switch;
        end
    end

    logic [7*NS-1:0] exp_seg;
    always @(negedge Clock) begin
        if (cmp_en) begin
            for (int i = 0; i < NS; i++) exp_seg[7*i +: 7] = m_seg[i];
            check("cyc_seg7", 64'(Seg7), 64'(exp_seg));
            check("cyc_led", 64'(Led), 64'(m_led));
            check("cyc_cursor_h", 64'(CursorH), 64'(m_ch));
            check("cyc_cursor_v", 64'(CursorV), 64'(m_cv));
            check("cyc_rd_data", 64'(CrRdData), 64'(m_rd));
        end
    end

    task automatic idle(input int n);
        CrWrEn = 1'b0;
        CrRdEn = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        CrWrEn = 1'b1; CrRdEn = 1'b0; CrAddr = a; CrWrData = d;
        @(negedge Clock);
        CrWrEn = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        CrRdEn = 1'b1; CrWrEn = 1'b0; CrAddr = a;
        @(negedge Clock);
        CrRdEn = 1'b0;
    endtask

    // Streams reads of BTN_LVL; data after edge k shows the level after edge k-1.
    task automatic watch_lvl(input string tag);
        CrAddr = 32'h2044; CrRdEn = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clock);
            if (k == 18) check({tag, "_lvl_edge17"}, 64'(CrRdData), 64'h0);
            if (k == 19) check({tag, "_lvl_edge18"}, 64'(CrRdData), 64'h1);
        end
        CrRdEn = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; CrWrEn = 1'b0; CrRdEn = 1'b0; CrAddr = '0; CrWrData = '0;
        Button = '0; Switch = '0;
        @(negedge Clock);
        cmp_en = 1'b1;
        @(negedge Clock);
        check("rst_led", 64'(Led), 64'h0);
        check("rst_seg7", 64'(Seg7), 64'h0);
        check("rst_rd", 64'(CrRdData), 64'h0);
        Rst = 1'b0;

        // Basic RW registers
        wr(32'h2000, 32'h7F);
        wr(32'h2040, 32'h3FF);
        check("seg0_out", 64'(Seg7[6:0]), 64'h7F);
        check("led_out", 64'(Led), 64'h3FF);
        rd(32'h2000); check("rd_seg0", 64'(CrRdData), 64'h7F);
        rd(32'h2040); check("rd_led", 64'(CrRdData), 64'h3FF);
        idle(2);      check("rd_hold", 64'(CrRdData), 64'h3FF);
        wr(32'h2014, 32'hFFFF_FFA5);
        check("seg5_out", 64'(Seg7[41:35]), 64'h25);
        rd(32'h2014); check("rd_seg5", 64'(CrRdData), 64'h25);
        rd(32'h2042); check("rd_addr_lsb_ignored", 64'(CrRdData), 64'h3FF);

        // Held press registers after 18 edges and raises the event
        Button[0] = 1'b1;
        watch_lvl("press0");
        rd(32'h2048); check("evt_after_press", 64'(CrRdData), 64'h1);
        Button[0] = 1'b0;

        // Short pulses on button 1 (5 and 15 cycles) are rejected
        Button[1] = 1'b1; idle(5); Button[1] = 1'b0; idle(25);
        rd(32'h2044); check("pulse5_lvl", 64'(CrRdData), 64'h0);
        rd(32'h2048); check("pulse5_evt", 64'(CrRdData), 64'h1);
        Button[1] = 1'b1; idle(15); Button[1] = 1'b0; idle(25);
        rd(32'h2048); check("pulse15_evt", 64'(CrRdData), 64'h1);
        // 16 cycles is just long enough
        Button[1] = 1'b1; idle(16); Button[1] = 1'b0; idle(25);
        rd(32'h2048); check("pulse16_evt", 64'(CrRdData), 64'h3);
        rd(32'h2044); check("pulse16_lvl_back", 64'(CrRdData), 64'h0);
        wr(32'h2048, 32'h2);
        rd(32'h2048); check("w1c_bit1", 64'(CrRdData), 64'h1);

        // Clear coincides with a debounced rise: set wins
        Button[0] = 1'b1; idle(17);
        wr(32'h2048, 32'h1);
        rd(32'h2048); check("set_beats_clear", 64'(CrRdData), 64'h1);
        wr(32'h2048, 32'h1);
        rd(32'h2048); check("evt_cleared", 64'(CrRdData), 64'h0);
        Button[0] = 1'b0; idle(22);

        // Read and write of the same register in one cycle
        CrWrEn = 1'b1; CrRdEn = 1'b1; CrAddr = 32'h2050; CrWrData = 32'hDEAD_BEEF;
        @(negedge Clock);
        idle(0);
        check("rw_same_old", 64'(CrRdData), 64'h0);
        check("cursor_h_out", 64'(CursorH), 64'hDEAD_BEEF);
        rd(32'h2050); check("rd_cursor_h", 64'(CrRdData), 64'hDEAD_BEEF);
        wr(32'h2054, 32'h1234_5678);
        rd(32'h2054); check("rd_cursor_v", 64'(CrRdData), 64'h1234_5678);

        // Unmapped, missing and read-only locations
        rd(32'h2018); check("rd_seg6_absent", 64'(CrRdData), 64'h0);
        rd(32'h2050);
        rd(32'h2060); check("rd_unmapped", 64'(CrRdData), 64'h0);
        rd(32'h2050);
        rd(32'h3000); check("rd_miss", 64'(CrRdData), 64'h0);
        wr(32'h3040, 32'h0); check("wr_miss_led", 64'(Led), 64'h3FF);
        wr(32'h2018, 32'h55);
        rd(32'h2018); check("wr_seg6_ignored", 64'(CrRdData), 64'h0);
        Switch = 10'h2A5; idle(3);
        rd(32'h204C); check("rd_sw", 64'(CrRdData), 64'h2A5);
        wr(32'h204C, 32'h0);
        rd(32'h204C); check("wr_sw_ignored", 64'(CrRdData), 64'h2A5);
        wr(32'h2044, 32'h3);
        rd(32'h2044); check("wr_lvl_ignored", 64'(CrRdData), 64'h0);

        // Reset mid-debounce, with strobes active during reset
        Button[0] = 1'b1; idle(12);
        Rst = 1'b1; CrWrEn = 1'b1; CrRdEn = 1'b1; CrAddr = 32'h2040; CrWrData = 32'h155;
        @(negedge Clock);
        @(negedge Clock);
        check("rst2_led", 64'(Led), 64'h0);
        check("rst2_seg7", 64'(Seg7), 64'h0);
        check("rst2_cursor_h", 64'(CursorH), 64'h0);
        check("rst2_cursor_v", 64'(CursorV), 64'h0);
        check("rst2_rd", 64'(CrRdData), 64'h0);
        CrWrEn = 1'b0; CrRdEn = 1'b0; Rst = 1'b0;
        watch_lvl("after_rst");
        rd(32'h2048); check("evt_after_rst", 64'(CrRdData), 64'h1);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
